// File: rtl/elelock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elelock_pkg
// Purpose  : Shared types and constants for the electronic lock controller.
// Revision : 1.0 - initial release
// ============================================================================
package elelock_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    ENTRY   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } elelock_state_t;

  typedef logic [3:0] digit_t;

  localparam digit_t NO_KEY = 4'hF;

  // Counter width for a limit n; never narrower than one bit.
  function automatic int cntw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/elelock_keyenc.sv
`default_nettype none
// ============================================================================
// Module   : elelock_keyenc
// Purpose  : Combinational one-hot ten-key to BCD encoder; zero/multi-hot
//            input yields valid=0 and digit=NO_KEY.
// Revision : 1.0 - initial release
// ============================================================================
module elelock_keyenc
  import elelock_pkg::*;
(
  input  logic [9:0] tenkey,
  output digit_t     digit,
  output logic       valid
);

  logic [3:0] w_ones;
  digit_t     w_idx;

  always_comb begin
    w_ones = 4'd0;
    w_idx  = NO_KEY;
    for (int i = 0; i < 10; i++) begin
      if (tenkey[i]) begin
        w_ones = w_ones + 4'd1;
        w_idx  = digit_t'(i);
      end
    end
    valid = (w_ones == 4'd1);
    digit = valid ? w_idx : NO_KEY;
  end

endmodule
`default_nettype wire

// File: rtl/elelock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : elelock_ctrl
// Purpose  : Ten-key code-entry lock sequencer with failed-attempt lockout.
//            Optional auto-relock from OPEN when ELELOCK_AUTORELOCK_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module elelock_ctrl
  import elelock_pkg::*;
#(
  parameter int          DIGITS      = 4,
  parameter logic [31:0] SECRET      = 32'h0000_1357,
  parameter int          MAX_TRIES   = 3,
  parameter int          TIMEOUT_CYC = 500,
  parameter int          LOCKOUT_CYC = 1000,
  parameter int          RELOCK_CYC  = 2000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [9:0]                       tenkey,
  input  logic                             close,
  output logic                             lock,
  output logic                             alarm,
  output logic                             busy,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fails
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = cntw(DIGITS + 1);
  localparam int TW = cntw(TIMEOUT_CYC);
  localparam int LW = cntw(LOCKOUT_CYC);
  localparam int FW = $clog2(MAX_TRIES + 1);

  localparam logic [CW-1:0] c_CNT_LAST  = CW'(DIGITS - 1);
  localparam logic [TW-1:0] c_IDLE_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] c_LKO_LAST  = LW'(LOCKOUT_CYC - 1);
  localparam logic [BW-1:0] c_SECRET    = SECRET[BW-1:0];

  elelock_state_t  r_state, w_state_nxt;
  logic [9:0]      r_tenkey_q;
  logic [BW-1:0]   r_buf, w_buf_nxt, w_buf_shift;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [TW-1:0]   r_idle, w_idle_nxt;
  logic [LW-1:0]   r_lko, w_lko_nxt;
  logic [FW-1:0]   r_fails, w_fails_nxt;
  logic            r_lock, r_alarm, r_busy;
  digit_t          w_digit;
  logic            w_valid, w_press, w_eval;

`ifdef ELELOCK_AUTORELOCK_EN
  localparam int RW = cntw(RELOCK_CYC);
  localparam logic [RW-1:0] c_RELOCK_LAST = RW'(RELOCK_CYC - 1);
  logic [RW-1:0] r_relock, w_relock_nxt;
`endif

  elelock_keyenc u_keyenc (
    .tenkey (tenkey),
    .digit  (w_digit),
    .valid  (w_valid)
  );

  // A press is a clean one-hot level arriving after an all-released sample.
  assign w_press     = w_valid && (r_tenkey_q == 10'd0);
  assign w_buf_shift = BW'({r_buf, w_digit});

  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_idle_nxt  = r_idle;
    w_lko_nxt   = r_lko;
    w_fails_nxt = r_fails;
    w_eval      = 1'b0;
`ifdef ELELOCK_AUTORELOCK_EN
    w_relock_nxt = r_relock;
`endif
    case (r_state)
      LOCKED: begin
        if (w_press) begin
          w_buf_nxt   = w_buf_shift;
          w_cnt_nxt   = CW'(1);
          w_idle_nxt  = '0;
          w_state_nxt = ENTRY;
          w_eval      = (DIGITS == 1);
        end
      end
      ENTRY: begin
        if (close) begin
          w_state_nxt = LOCKED;
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_idle_nxt  = '0;
        end else if (w_press) begin
          w_buf_nxt  = w_buf_shift;
          w_cnt_nxt  = r_cnt + CW'(1);
          w_idle_nxt = '0;
          w_eval     = (r_cnt == c_CNT_LAST);
        end else if (r_idle == c_IDLE_LAST) begin
          w_state_nxt = LOCKED;
          w_buf_nxt   = '0;
          w_cnt_nxt   = '0;
          w_idle_nxt  = '0;
        end else begin
          w_idle_nxt = r_idle + TW'(1);
        end
      end
      OPEN: begin
        if (close) begin
          w_state_nxt = LOCKED;
`ifdef ELELOCK_AUTORELOCK_EN
          w_relock_nxt = '0;
        end else if (r_relock == c_RELOCK_LAST) begin
          w_state_nxt  = LOCKED;
          w_relock_nxt = '0;
        end else begin
          w_relock_nxt = r_relock + RW'(1);
`endif
        end
      end
      LOCKOUT: begin
        if (r_lko == c_LKO_LAST) begin
          w_state_nxt = LOCKED;
          w_lko_nxt   = '0;
          w_fails_nxt = '0;
        end else begin
          w_lko_nxt = r_lko + LW'(1);
        end
      end
      default: w_state_nxt = LOCKED;
    endcase

    // Final digit: the shifted buffer already holds the complete code.
    if (w_eval) begin
      w_buf_nxt  = '0;
      w_cnt_nxt  = '0;
      w_idle_nxt = '0;
      if (w_buf_shift == c_SECRET) begin
        w_state_nxt = OPEN;
        w_fails_nxt = '0;
      end else if ((int'(r_fails) + 1) < MAX_TRIES) begin
        w_state_nxt = LOCKED;
        w_fails_nxt = r_fails + FW'(1);
      end else begin
        w_state_nxt = LOCKOUT;
        w_fails_nxt = FW'(MAX_TRIES);
        w_lko_nxt   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= LOCKED;
      r_tenkey_q <= '0;
      r_buf      <= '0;
      r_cnt      <= '0;
      r_idle     <= '0;
      r_lko      <= '0;
      r_fails    <= '0;
      r_lock     <= 1'b1;
      r_alarm    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tenkey_q <= tenkey;
      r_buf      <= w_buf_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idle     <= w_idle_nxt;
      r_lko      <= w_lko_nxt;
      r_fails    <= w_fails_nxt;
      r_lock     <= (w_state_nxt != OPEN);
      r_alarm    <= (w_state_nxt == LOCKOUT);
      r_busy     <= (w_state_nxt == ENTRY);
    end
  end

`ifdef ELELOCK_AUTORELOCK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) r_relock <= '0;
    else        r_relock <= w_relock_nxt;
  end
`endif

  assign lock  = r_lock;
  assign alarm = r_alarm;
  assign busy  = r_busy;
  assign fails = r_fails;

endmodule
`default_nettype wire

// File: tb/tb_elelock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_elelock_ctrl
// Purpose  : Table-driven plus directed-sequence self-checking bench.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elelock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] tenkey = '0;
  logic       close = 1'b0;
  logic       lock, alarm, busy;
  logic [1:0] fails;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic       rn;
    logic [9:0] tk;
    logic       cl;
    logic       lk;
    logic       al;
    logic       bz;
    logic [1:0] fl;
  } vec_t;

  vec_t tbl[$];

  elelock_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tenkey (tenkey),
    .close  (close),
    .lock   (lock),
    .alarm  (alarm),
    .busy   (busy),
    .fails  (fails)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] key(input int d);
    logic [9:0] one;
    one = 10'd1;
    return one << d;
  endfunction

  task automatic add(input logic rn, input logic [9:0] tk, input logic cl,
                     input logic lk, input logic al, input logic bz, input logic [1:0] fl);
    tbl.push_back('{rn: rn, tk: tk, cl: cl, lk: lk, al: al, bz: bz, fl: fl});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic lk, input logic al,
                     input logic bz, input logic [1:0] fl);
    n_chk++;
    if (lock !== lk || alarm !== al || busy !== bz || fails !== fl) begin
      n_err++;
      $display("FAIL %s: got lock=%0b alarm=%0b busy=%0b fails=%0d, want lock=%0b alarm=%0b busy=%0b fails=%0d",
               nm, lock, alarm, busy, fails, lk, al, bz, fl);
    end
  endtask

  task automatic press(input int d);
    tenkey = key(d);
    step;
    tenkey = '0;
    step;
  endtask

  // Leaves the final key held so the caller can check the evaluation edge.
  task automatic enter(input int a, input int b, input int c, input int d);
    press(a);
    press(b);
    press(c);
    tenkey = key(d);
    step;
  endtask

  initial begin
    int cnt;
    // rn tk cl | lock alarm busy fails
    add(0, '0,      0, 1, 0, 0, 0);
    add(1, '0,      0, 1, 0, 0, 0);
    add(1, key(1),  0, 1, 0, 1, 0);
    add(1, key(1),  0, 1, 0, 1, 0);
    add(1, key(1),  0, 1, 0, 1, 0);
    add(1, '0,      0, 1, 0, 1, 0);
    add(1, key(3),  0, 1, 0, 1, 0);
    add(1, '0,      0, 1, 0, 1, 0);
    add(1, key(5),  0, 1, 0, 1, 0);
    add(1, key(5),  0, 1, 0, 1, 0);
    add(1, '0,      0, 1, 0, 1, 0);
    add(1, key(7),  0, 0, 0, 0, 0);
    add(1, key(7),  0, 0, 0, 0, 0);
    add(1, '0,      0, 0, 0, 0, 0);
    add(1, key(1),  0, 0, 0, 0, 0);
    add(1, '0,      0, 0, 0, 0, 0);
    add(1, '0,      1, 1, 0, 0, 0);
    add(1, '0,      0, 1, 0, 0, 0);
    add(1, 10'b0000000110, 0, 1, 0, 0, 0);
    add(1, '0,      0, 1, 0, 0, 0);
    add(1, key(1),  0, 1, 0, 1, 0);
    add(1, '0,      0, 1, 0, 1, 0);
    add(1, 10'b0000000110, 0, 1, 0, 1, 0);
    add(1, '0,      0, 1, 0, 1, 0);
    add(1, key(3),  0, 1, 0, 1, 0);
    add(1, '0,      0, 1, 0, 1, 0);
    add(1, key(5),  0, 1, 0, 1, 0);
    add(1, '0,      0, 1, 0, 1, 0);
    add(1, key(7),  0, 0, 0, 0, 0);
    add(1, '0,      0, 0, 0, 0, 0);
    add(1, '0,      1, 1, 0, 0, 0);
    add(1, '0,      0, 1, 0, 0, 0);
    add(1, key(1),  0, 1, 0, 1, 0);
    add(1, key(3),  1, 1, 0, 0, 0);
    add(1, '0,      0, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n  = tbl[i].rn;
      tenkey = tbl[i].tk;
      close  = tbl[i].cl;
      step;
      chk($sformatf("vec%0d", i), tbl[i].lk, tbl[i].al, tbl[i].bz, tbl[i].fl);
    end
    close = 1'b0;
    tenkey = '0;
    step;

    // Three wrong codes: fails 1, 2, then lockout.
    enter(1, 3, 5, 8); chk("wrong1", 1, 0, 0, 1); tenkey = '0; step;
    enter(1, 3, 5, 8); chk("wrong2", 1, 0, 0, 2); tenkey = '0; step;
    enter(1, 3, 5, 8); chk("wrong3", 1, 1, 0, 3);
    cnt = 1;
    for (int i = 0; i < 1100 && alarm; i++) begin
      tenkey = (i % 7 == 3 && i < 980) ? key(5) : 10'd0;
      close  = (i % 50 == 10);
      step;
      if (alarm) cnt++;
    end
    close = 1'b0;
    tenkey = '0;
    n_chk++;
    if (cnt != 1000) begin
      n_err++;
      $display("FAIL lockout_len: got %0d cycles, want 1000", cnt);
    end
    chk("after_lockout", 1, 0, 0, 0);
    step;
    chk("after_lockout_idle", 1, 0, 0, 0);

    // Idle timeout keeps fails.
    enter(1, 3, 5, 8); chk("wrong_pre_to", 1, 0, 0, 1); tenkey = '0; step;
    press(1);
    press(3);
    repeat (498) step;
    chk("to_still_busy", 1, 0, 1, 1);
    step;
    chk("to_expired", 1, 0, 0, 1);
    enter(1, 3, 5, 7); chk("open_after_to", 0, 0, 0, 0);
    tenkey = '0; close = 1'b1; step; close = 1'b0;
    chk("close_after_to", 1, 0, 0, 0);

    // Reset mid-entry with fails=2.
    enter(1, 3, 5, 8); tenkey = '0; step;
    enter(1, 3, 5, 8); chk("pre_rst_fails2", 1, 0, 0, 2); tenkey = '0; step;
    press(1);
    chk("pre_rst_busy", 1, 0, 1, 2);
    rst_n = 1'b0; step;
    chk("rst_mid", 1, 0, 0, 0);
    rst_n = 1'b1; step;
    chk("rst_release", 1, 0, 0, 0);

    // A long hold is a single press.
    tenkey = key(1);
    repeat (20) step;
    tenkey = '0; step;
    chk("hold_one_press", 1, 0, 1, 0);
    press(3);
    press(5);
    tenkey = key(7); step;
    chk("hold_open", 0, 0, 0, 0);
    tenkey = '0; step;

    // OPEN persistence / auto-relock.
    cnt = 1;
    for (int i = 0; i < 3100 && !lock; i++) begin
      step;
      if (!lock) cnt++;
    end
`ifdef ELELOCK_AUTORELOCK_EN
    n_chk++;
    if (cnt != 2000) begin
      n_err++;
      $display("FAIL relock_len: got %0d open cycles, want 2000", cnt);
    end
    chk("relocked", 1, 0, 0, 0);
`else
    n_chk++;
    if (cnt < 3000) begin
      n_err++;
      $display("FAIL stay_open: got %0d open cycles, want >=3000", cnt);
    end
    close = 1'b1; step; close = 1'b0;
    chk("close_final", 1, 0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
